// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam int unsigned RF_MAX_RD    = 4;
  localparam int unsigned RF_ZERO_ADDR = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address compare, write bypass mux and output register.
// Bypass is enabled by defining REGFILE_BYPASS_EN (write-first); otherwise read-first.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_fire,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [DATA_W-1:0] rd_d, rd_q;
  logic              hit;
  logic              zero_hit;

  // wr_fire already excludes dropped writes, so a dropped write is never bypassed
  assign hit      = BypassEn && wr_fire && (wr_addr == rd_addr);
  assign zero_hit = (ZERO_REG != 0) && (rd_addr == AW'(RF_ZERO_ADDR));

  always_comb begin
    rd_d = mem_data;
    if (hit) begin
      rd_d = wr_data;
    end
    if (zero_hit || busy) begin
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_RD registered read ports, one write port, clear sequencer.
// Same-cycle write/read behaviour is selected by the REGFILE_BYPASS_EN macro.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              clr_we;
  logic              wr_fire;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign busy = (state_q == RF_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  // Writes to x0 with ZERO_REG set are dropped here, so neither storage nor bypass sees them
  assign wr_fire = wr_en && !busy && !rst &&
                   !((ZERO_REG != 0) && (wr_addr == AW'(RF_ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_W-1:0] mem_rd;
    assign mem_rd = mem_q[rd_addr[p*AW +: AW]];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy),
      .rd_addr (rd_addr[p*AW +: AW]),
      .mem_data(mem_rd),
      .wr_fire (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with a read-data scoreboard.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr_req;
  logic            busy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  regfile_multiport #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .NUM_RD  (NR),
    .ZERO_REG(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clr_req(clr_req),
    .busy   (busy),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle from a negedge: drive, push expectations, then pop and compare at next negedge.
  task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                       input logic [31:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1, input bit chk);
    exp_t e;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {a1, a0};
    if (chk) begin
      e.tag = tag; e.port = 0; e.data = e0; sb.push_back(e);
      e.tag = tag; e.port = 1; e.data = e1; sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_p%0d", e.tag, e.port), rd_data[e.port*DW +: DW], e.data);
    end
  endtask

  task automatic count_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    int n;
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rd0", rd_data[0 +: DW], 32'd0);
    check("reset_rd1", rd_data[DW +: DW], 32'd0);

    // 1: post-reset clear takes DEPTH cycles, then everything reads zero
    rst = 1'b0;
    count_busy("init_busy_cycles", DEPTH);
    for (int a = 0; a < DEPTH; a += 2) begin
      cycle("init_zero", 1'b0, '0, '0, AW'(a), AW'(a + 1), 32'd0, 32'd0, 1'b1);
    end

    // 2: write then dual-port read
    cycle("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    cycle("rd_x5", 1'b0, '0, '0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    // 3: x0 is hardwired to zero, including same-cycle bypass
    cycle("wr_rd_x0", 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    cycle("rd_x0", 1'b0, '0, '0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);

    // 4: same-cycle write/read of x7
    cycle("wr_x7", 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    cycle("same_cyc_x7", 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1);
`else
    cycle("same_cyc_x7", 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 32'h1, 32'hDEADBEEF, 1'b1);
`endif
    cycle("rd_x7", 1'b0, '0, '0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);

    // 5: clear request; write and second clr_req during busy are ignored
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd1);
    rd_addr = {5'd5, 5'd5};
    n = 0;
    while (busy && n < 100) begin
      wr_en   = (n == 5);
      clr_req = (n == 5);
      wr_addr = 5'd3;
      wr_data = 32'hFFFFFFFF;
      n++;
      @(negedge clk);
      if (n == 7) check("busy_rd_zero", rd_data[0 +: DW], 32'd0);
    end
    wr_en = 1'b0; clr_req = 1'b0;
    check("clr_busy_cycles", n, DEPTH);
    cycle("after_clr", 1'b0, '0, '0, 5'd3, 5'd5, 32'd0, 32'd0, 1'b1);

    // 6: reset mid-clear restarts the sequence
    cycle("wr_x9", 1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    cycle("wr_x20", 1'b1, 5'd20, 32'h66, 5'd9, 5'd0, 32'h55, 32'd0, 1'b1);
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    count_busy("rst_mid_cycles", DEPTH);
    cycle("after_rst_clr", 1'b0, '0, '0, 5'd9, 5'd20, 32'd0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
